// File: rtl/denise_pkg.sv
// Shared constants and helpers for the Denise playfield engine and its delay lines.
package denise_pkg;

    localparam int MAX_PLANES      = 8;
    // Plane 1 is index 0, so the odd planes (1,3,5,7) sit at even indices.
    localparam int PF1_FIRST_PLANE = 0;
    localparam int PF2_FIRST_PLANE = 1;
    localparam int PLANE_STRIDE    = 2;
    localparam int PF2P_QUIRK_MIN  = 6;

    // Colour offset for playfield 2 in AGA dual-playfield mode: 0,2,4,8,...,128.
    function automatic logic [7:0] pf2_offset(input logic [2:0] sel);
        return (sel == 3'd0) ? 8'h00 : (8'h01 << sel);
    endfunction

endpackage

// File: rtl/denise_pf_delay.sv
// Variable-tap pixel delay line for one playfield group; tap 0 is the undelayed input.
module denise_pf_delay
    import denise_pkg::*;
#(
    parameter int WIDTH    = MAX_PLANES / 2,
    parameter int SCROLL_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en_i,
    input  logic [WIDTH-1:0]    din_i,
    input  logic [SCROLL_W-1:0] tap_i,
    output logic [WIDTH-1:0]    dout_o
);

    localparam int DEPTH = 1 << SCROLL_W;

    // line_q[h] holds the group bits from h enabled cycles ago.
    logic [WIDTH-1:0] line_q [1:DEPTH-1];

    // NOTE: the delay stages are reset on purpose so a mid-line reset discards in-flight pixels.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < DEPTH; i++) line_q[i] <= '0;
        end else if (en_i) begin
            line_q[1] <= din_i;
            for (int i = 2; i < DEPTH; i++) line_q[i] <= line_q[i-1];
        end
    end

    always_comb begin
        dout_o = din_i;
        for (int i = 1; i < DEPTH; i++) begin
            if (tap_i == SCROLL_W'(i)) dout_o = line_q[i];
        end
    end

endmodule

// File: rtl/denise_pf_engine.sv
// Denise playfield engine: shift, scroll and priority resolve to a registered colour index.
// Define DENISE_PF_SCROLL_EN to instantiate the scroll delay lines; otherwise pf1h/pf2h are ignored.
module denise_pf_engine
    import denise_pkg::*;
#(
    parameter int NPLANES  = 8,
    parameter int DW       = 16,
    parameter int SCROLL_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk7_en,
    input  logic [NPLANES*DW-1:0]   bpldat,
    input  logic                    load,
    input  logic [3:0]              bpu,
    input  logic [SCROLL_W-1:0]     pf1h,
    input  logic [SCROLL_W-1:0]     pf2h,
    input  logic                    dblpf,
    input  logic                    aga,
    input  logic [2:0]              pf2of,
    input  logic [6:0]              bplcon2,
    output logic [2:1]              nplayfield,
    output logic [7:0]              plfdata
);

    localparam int NGRP = NPLANES / 2;

    logic [DW-1:0]      shift_q [NPLANES];
    logic [NPLANES-1:0] cur_bits;
    logic [NGRP-1:0]    pf1_in, pf2_in, pf1_bits, pf2_bits;
    logic [7:0]         pix;
    logic               pf1_valid, pf2_valid;
    logic [7:0]         pf1_idx, pf2_idx;
    logic [7:0]         plfdata_q, plfdata_d;
    logic [2:1]         npf_q, npf_d;
    logic               unused_bplcon2;

    assign unused_bplcon2 = ^bplcon2[2:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NPLANES; p++) shift_q[p] <= '0;
        end else if (clk7_en) begin
            for (int p = 0; p < NPLANES; p++) begin
                if (load) shift_q[p] <= bpldat[p*DW +: DW];
                else      shift_q[p] <= {shift_q[p][DW-2:0], 1'b0};
            end
        end
    end

    // Masking against bpu also clamps values above NPLANES, since p never reaches them.
    always_comb begin
        cur_bits = '0;
        pf1_in   = '0;
        pf2_in   = '0;
        for (int p = 0; p < NPLANES; p++) cur_bits[p] = shift_q[p][DW-1] & (p < int'(bpu));
        for (int j = 0; j < NGRP; j++) begin
            pf1_in[j] = cur_bits[PF1_FIRST_PLANE + PLANE_STRIDE*j];
            pf2_in[j] = cur_bits[PF2_FIRST_PLANE + PLANE_STRIDE*j];
        end
    end

`ifdef DENISE_PF_SCROLL_EN
    denise_pf_delay #(.WIDTH(NGRP), .SCROLL_W(SCROLL_W)) u_pf1_delay (
        .clk    (clk),
        .reset  (reset),
        .en_i   (clk7_en),
        .din_i  (pf1_in),
        .tap_i  (pf1h),
        .dout_o (pf1_bits)
    );

    denise_pf_delay #(.WIDTH(NGRP), .SCROLL_W(SCROLL_W)) u_pf2_delay (
        .clk    (clk),
        .reset  (reset),
        .en_i   (clk7_en),
        .din_i  (pf2_in),
        .tap_i  (pf2h),
        .dout_o (pf2_bits)
    );
`else
    logic unused_scroll;
    assign unused_scroll = ^{pf1h, pf2h};
    assign pf1_bits      = pf1_in;
    assign pf2_bits      = pf2_in;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pix = '0;
        for (int j = 0; j < NGRP; j++) begin
            pix[PF1_FIRST_PLANE + PLANE_STRIDE*j] = pf1_bits[j];
            pix[PF2_FIRST_PLANE + PLANE_STRIDE*j] = pf2_bits[j];
        end
    end

    always_comb begin
        pf1_valid = |pf1_bits;
        pf2_valid = |pf2_bits;
        pf1_idx   = {4'b0000, pix[6], pix[4], pix[2], pix[0]};
        pf2_idx   = aga ? ({4'b0000, pix[7], pix[5], pix[3], pix[1]} + pf2_offset(pf2of))
                        : {4'b0000, 1'b1, pix[5], pix[3], pix[1]};
        plfdata_d = 8'h00;
        npf_d     = 2'b00;
        if (dblpf) begin
            npf_d = {pf2_valid, pf1_valid};
            if (bplcon2[6]) begin
                if (pf2_valid)      plfdata_d = pf2_idx;
                else if (pf1_valid) plfdata_d = pf1_idx;
            end else begin
                if (pf1_valid)      plfdata_d = pf1_idx;
                else if (pf2_valid) plfdata_d = pf2_idx;
            end
        end else begin
            npf_d = {|pix, 1'b0};
            // OCS quirk: a high pf2p with plane 5 set forces colour 16.
            if (!aga && (bplcon2[5:3] >= 3'(PF2P_QUIRK_MIN)) && pix[4]) plfdata_d = 8'h10;
            else                                                         plfdata_d = pix;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            plfdata_q <= 8'h00;
            npf_q     <= 2'b00;
        end else if (clk7_en) begin
            plfdata_q <= plfdata_d;
            npf_q     <= npf_d;
        end
    end

    assign plfdata    = plfdata_q;
    assign nplayfield = npf_q;

endmodule

// File: tb/tb_denise_pf_engine.sv
// Directed self-checking bench for denise_pf_engine; latencies follow DENISE_PF_SCROLL_EN.
module tb_denise_pf_engine;

    localparam int NPLANES  = 8;
    localparam int DW       = 16;
    localparam int SCROLL_W = 4;
`ifdef DENISE_PF_SCROLL_EN
    localparam bit SCROLL_ON = 1'b1;
`else
    localparam bit SCROLL_ON = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset, clk7_en, load, dblpf, aga;
    logic [NPLANES*DW-1:0] bpldat;
    logic [3:0]            bpu;
    logic [SCROLL_W-1:0]   pf1h, pf2h;
    logic [2:0]            pf2of;
    logic [6:0]            bplcon2;
    logic [2:1]            nplayfield;
    logic [7:0]            plfdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    denise_pf_engine #(.NPLANES(NPLANES), .DW(DW), .SCROLL_W(SCROLL_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk7_en    (clk7_en),
        .bpldat     (bpldat),
        .load       (load),
        .bpu        (bpu),
        .pf1h       (pf1h),
        .pf2h       (pf2h),
        .dblpf      (dblpf),
        .aga        (aga),
        .pf2of      (pf2of),
        .bplcon2    (bplcon2),
        .nplayfield (nplayfield),
        .plfdata    (plfdata)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_plane(input int p, input logic [DW-1:0] w);
        bpldat[p*DW +: DW] = w;
    endtask

    task automatic fire();
        load = 1'b1;
        tick();
        load   = 1'b0;
        bpldat = '0;
    endtask

    // Expects a single pixel at enabled cycle 'at' after the load edge, zero on its neighbours.
    task automatic expect_pixel(input string tag, input int at, input logic [7:0] val,
                                input logic [2:1] npf);
        for (int n = 1; n <= at + 1; n++) begin
            tick();
            if (n == at) begin
                check({tag, " index"}, plfdata, val);
                check({tag, " valid"}, {6'b0, nplayfield}, {6'b0, npf});
            end else if (n == at - 1 || n == at + 1) begin
                check({tag, " idle"}, plfdata, 8'h00);
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        clk7_en = 1'b1;
        load    = 1'b0;
        bpldat  = '0;
        bpu     = 4'd8;
        pf1h    = '0;
        pf2h    = '0;
        dblpf   = 1'b0;
        aga     = 1'b0;
        pf2of   = 3'd0;
        bplcon2 = 7'h00;
        tick();
        tick();
        reset = 1'b0;
        check("reset plfdata", plfdata, 8'h00);
        check("reset nplayfield", {6'b0, nplayfield}, 8'h00);

        // Single playfield, no scroll.
        set_plane(0, 16'h8000);
        fire();
        expect_pixel("pf1 h0", 1, 8'h01, 2'b10);

        // Scroll delays on each group.
        do_reset();
        pf1h = 4'd5;
        set_plane(0, 16'h8000);
        fire();
        expect_pixel("pf1 h5", SCROLL_ON ? 6 : 1, 8'h01, 2'b10);

        do_reset();
        pf2h = 4'd3;
        set_plane(1, 16'h8000);
        fire();
        expect_pixel("pf2 h3", SCROLL_ON ? 4 : 1, 8'h02, 2'b10);
        pf1h = '0;
        pf2h = '0;

        // Dual playfield priority.
        do_reset();
        dblpf = 1'b1; aga = 1'b1; pf2of = 3'd3; bplcon2 = 7'h40;
        set_plane(0, 16'h8000); set_plane(1, 16'h8000);
        fire();
        expect_pixel("dual aga pf2pri", 1, 8'h09, 2'b11);
        bplcon2 = 7'h00;
        set_plane(0, 16'h8000); set_plane(1, 16'h8000);
        fire();
        expect_pixel("dual aga pf1pri", 1, 8'h01, 2'b11);
        aga = 1'b0; bplcon2 = 7'h40;
        set_plane(0, 16'h8000); set_plane(1, 16'h8000);
        fire();
        expect_pixel("dual ocs pf2pri", 1, 8'h09, 2'b11);
        aga = 1'b1;
        set_plane(0, 16'h8000);
        fire();
        expect_pixel("dual pf2 transparent", 1, 8'h01, 2'b01);
        aga = 1'b0; bplcon2 = 7'h00;
        set_plane(1, 16'h8000);
        fire();
        expect_pixel("dual pf1 transparent", 1, 8'h09, 2'b10);
        aga = 1'b1; pf2of = 3'd7; bplcon2 = 7'h40;
        set_plane(3, 16'h8000);
        fire();
        expect_pixel("dual aga offset wrap", 1, 8'h82, 2'b10);

        // OCS pf2p quirk on plane 5.
        do_reset();
        dblpf = 1'b0; aga = 1'b0; pf2of = 3'd0; bplcon2 = 7'h30; bpu = 4'd5;
        set_plane(4, 16'hFFFF);
        fire();
        for (int n = 1; n <= 16; n++) begin
            tick();
            check("quirk run", plfdata, 8'h10);
        end
        tick();
        check("quirk end", plfdata, 8'h00);
        aga = 1'b1;
        set_plane(4, 16'hFFFF);
        fire();
        for (int n = 1; n <= 16; n++) begin
            tick();
            check("aga plane5 run", plfdata, 8'h10);
        end
        aga = 1'b0;
        set_plane(0, 16'hFFFF); set_plane(4, 16'hFFFF);
        fire();
        tick();
        check("quirk overrides plane1", plfdata, 8'h10);
        do_reset();
        aga = 1'b1;
        set_plane(0, 16'hFFFF); set_plane(4, 16'hFFFF);
        fire();
        tick();
        check("aga plain data", plfdata, 8'h11);
        do_reset();
        aga = 1'b0; bplcon2 = 7'h28;
        set_plane(0, 16'hFFFF); set_plane(4, 16'hFFFF);
        fire();
        tick();
        check("pf2p 5 no quirk", plfdata, 8'h11);
        do_reset();

        // Active plane count.
        bplcon2 = 7'h00;
        for (int p = 0; p < NPLANES; p++) set_plane(p, 16'hFFFF);
        bpu = 4'd2;
        fire();
        tick();
        check("bpu 2", plfdata, 8'h03);
        do_reset();
        for (int p = 0; p < NPLANES; p++) set_plane(p, 16'hFFFF);
        bpu = 4'd12;
        fire();
        tick();
        check("bpu 12 clamp", plfdata, 8'hFF);
        do_reset();
        for (int p = 0; p < NPLANES; p++) set_plane(p, 16'hFFFF);
        bpu = 4'd0;
        fire();
        tick();
        check("bpu 0 index", plfdata, 8'h00);
        check("bpu 0 valid", {6'b0, nplayfield}, 8'h00);
        do_reset();

        // Reset mid-word while the pixel enable is low.
        bpu = 4'd8;
        set_plane(0, 16'hFFFF);
        fire();
        for (int n = 1; n <= 3; n++) begin
            tick();
            check("pre-reset run", plfdata, 8'h01);
        end
        clk7_en = 1'b0;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        check("mid reset index", plfdata, 8'h00);
        check("mid reset valid", {6'b0, nplayfield}, 8'h00);
        clk7_en = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            tick();
            check("post-reset flush", plfdata, 8'h00);
        end

        // Outputs hold while the pixel enable is low.
        set_plane(0, 16'h8000);
        fire();
        tick();
        check("hold start", plfdata, 8'h01);
        clk7_en = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            tick();
            check("hold en low", plfdata, 8'h01);
        end
        clk7_en = 1'b1;
        tick();
        check("hold release", plfdata, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
